// File: rtl/eth_tx_pause_insert_if.sv
// Byte-wide AXI-stream channel used on both sides of the TX PAUSE inserter.
interface eth_tx_pause_insert_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/eth_tx_pause_insert.sv
// 802.3x PAUSE frame inserter on the 8-bit TX stream between the TX FIFO and the 1G MAC.
// FIFO frames pass through with zero latency; PAUSE frames are sourced at frame boundaries.
module eth_tx_pause_insert (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    eth_tx_pause_insert_if.slave  s_axis,
    eth_tx_pause_insert_if.master m_axis,
    input  logic                  pause_req,
    input  logic [15:0]           pause_quanta,
    input  logic [47:0]           src_mac,
    output logic                  pause_busy,
    output logic                  pause_sent
);

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned QUANTA_W  = 16;
    localparam int unsigned MAC_W     = 48;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned FRAME_LEN = 60;

    localparam logic [MAC_W-1:0] DA_MAC    = 48'h0180C2000001;
    localparam logic [15:0]      ETHERTYPE = 16'h8808;
    localparam logic [15:0]      OPCODE    = 16'h0001;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                pending;
    logic [QUANTA_W-1:0] pend_quanta;
    logic [QUANTA_W-1:0] act_quanta;
    logic [MAC_W-1:0]    act_mac;
    logic [CNT_W-1:0]    cnt;

    logic                enter_pause;
    logic                pause_hs;
    logic                fwd;
    logic [DATA_W-1:0]   pause_byte;

    logic                s_ready;
    logic                m_valid;
    logic [DATA_W-1:0]   m_data;
    logic                m_last;
    logic                m_user;

    // State register
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream muxing; a pending request in IDLE blocks the FIFO for one cycle
    always_comb begin
        state_nxt   = state;
        fwd         = 1'b0;
        enter_pause = 1'b0;
        pause_sent  = 1'b0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        m_user      = 1'b0;

        unique case (state)
            IDLE: begin
                if (pending) begin
                    enter_pause = 1'b1;
                    state_nxt   = PAUSE;
                end else begin
                    fwd = 1'b1;
                    if (s_axis.tvalid && m_axis.tready && !s_axis.tlast) begin
                        state_nxt = PASS;
                    end
                end
            end
            PASS: begin
                fwd = 1'b1;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
                    state_nxt = IDLE;
                end
            end
            PAUSE: begin
                m_valid = 1'b1;
                m_data  = pause_byte;
                m_last  = (cnt == LAST_IDX);
                if (m_axis.tready && (cnt == LAST_IDX)) begin
                    pause_sent = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (fwd) begin
            s_ready = m_axis.tready;
            m_valid = s_axis.tvalid;
            m_data  = s_axis.tdata;
            m_last  = s_axis.tlast;
            m_user  = s_axis.tuser;
        end
    end

    assign pause_hs = (state == PAUSE) && m_axis.tready;

    // Request capture, PAUSE field snapshot and byte counter
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            pending     <= 1'b0;
            pend_quanta <= '0;
            act_quanta  <= '0;
            act_mac     <= '0;
            cnt         <= '0;
        end else begin
            if (pause_req) begin
                pending     <= 1'b1;
                pend_quanta <= pause_quanta;
            end else if (enter_pause) begin
                pending <= 1'b0;
            end

            if (enter_pause) begin
                act_quanta <= pend_quanta;
                act_mac    <= src_mac;
                cnt        <= '0;
            end else if (pause_hs) begin
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // PAUSE frame byte at the current counter position; the tail is zero padding
    always_comb begin
        pause_byte = '0;
        case (cnt)
            6'd0:    pause_byte = DA_MAC[47:40];
            6'd1:    pause_byte = DA_MAC[39:32];
            6'd2:    pause_byte = DA_MAC[31:24];
            6'd3:    pause_byte = DA_MAC[23:16];
            6'd4:    pause_byte = DA_MAC[15:8];
            6'd5:    pause_byte = DA_MAC[7:0];
            6'd6:    pause_byte = act_mac[47:40];
            6'd7:    pause_byte = act_mac[39:32];
            6'd8:    pause_byte = act_mac[31:24];
            6'd9:    pause_byte = act_mac[23:16];
            6'd10:   pause_byte = act_mac[15:8];
            6'd11:   pause_byte = act_mac[7:0];
            6'd12:   pause_byte = ETHERTYPE[15:8];
            6'd13:   pause_byte = ETHERTYPE[7:0];
            6'd14:   pause_byte = OPCODE[15:8];
            6'd15:   pause_byte = OPCODE[7:0];
            6'd16:   pause_byte = act_quanta[15:8];
            6'd17:   pause_byte = act_quanta[7:0];
            default: pause_byte = '0;
        endcase
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tlast  = m_last;
    assign m_axis.tuser  = m_user;

    assign pause_busy = pending | (state == PAUSE);

endmodule

// File: tb/tb_eth_tx_pause_insert.sv
// Self-checking bench for eth_tx_pause_insert: vector table for the forward path,
// scoreboarded FIFO and PAUSE frames for the multi-cycle scenarios.
`timescale 1ns/1ps
module tb_eth_tx_pause_insert;

    localparam logic [47:0] SRC_MAC = 48'h020000000001;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic        pause_req;
    logic [15:0] pause_quanta;
    logic [47:0] src_mac;
    logic        pause_busy;
    logic        pause_sent;
    logic        ready_val = 1'b1;
    logic        rand_mode = 1'b0;
    logic        rand_bit  = 1'b1;

    always #5 tx_clk = ~tx_clk;

    eth_tx_pause_insert_if s_if ();
    eth_tx_pause_insert_if m_if ();

    assign m_if.tready = rand_mode ? rand_bit : ready_val;

    always @(posedge tx_clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    eth_tx_pause_insert dut (
        .tx_clk       (tx_clk),
        .tx_rst       (tx_rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .pause_req    (pause_req),
        .pause_quanta (pause_quanta),
        .src_mac      (src_mac),
        .pause_busy   (pause_busy),
        .pause_sent   (pause_sent)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       sent;
    } beat_t;

    typedef enum logic [1:0] { SRC_NONE, SRC_FIFO, SRC_PAUSE } src_t;

    beat_t       fifo_q[$];
    beat_t       exp_q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    src_t        cur_src    = SRC_NONE;
    logic        model_pending = 1'b0;
    logic [15:0] model_quanta  = '0;
    int          pause_idx  = 0;
    int          sent_count = 0;
    int          sent_cyc   = -1;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;
    logic        pass_window = 1'b0;
    logic        busy_seen   = 1'b0;

    always @(posedge tx_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected PAUSE frame as seen on m_axis
    function automatic void gen_pause(input logic [15:0] q, input logic [47:0] mac);
        logic [143:0] hdr;
        logic [143:0] sh;
        beat_t        b;
        hdr = {48'h0180C2000001, mac, 16'h8808, 16'h0001, q};
        for (int i = 0; i < 60; i++) begin
            sh     = hdr << (8 * i);
            b.data = (i < 18) ? sh[143:136] : 8'h00;
            b.last = (i == 59);
            b.user = 1'b0;
            b.sent = (i == 59);
            exp_q.push_back(b);
        end
    endfunction

    // Output monitor: sampled mid-cycle, one scoreboard pop per handshake
    always @(negedge tx_clk) begin : monitor
        beat_t got;
        beat_t want;
        logic  have;
        if (tx_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, prev_data}));
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            if (pass_window && pause_busy) busy_seen = 1'b1;
            if (m_if.tvalid && m_if.tready) begin
                have = 1'b0;
                want = '0;
                if (cur_src == SRC_NONE) begin
                    if (model_pending) begin
                        gen_pause(model_quanta, src_mac);
                        model_pending = 1'b0;
                        cur_src       = SRC_PAUSE;
                        pause_idx     = 0;
                    end else begin
                        cur_src = SRC_FIFO;
                    end
                end
                got = {m_if.tdata, m_if.tlast, m_if.tuser, pause_sent};
                if (cur_src == SRC_PAUSE && exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    pause_idx++;
                    have = 1'b1;
                end else if (cur_src == SRC_FIFO && fifo_q.size() > 0) begin
                    want = fifo_q.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", got, cyc);
                end else begin
                    chk((cur_src == SRC_PAUSE) ? "pause_beat" : "fifo_beat", 64'(got), 64'(want));
                end
                if (m_if.tlast) cur_src = SRC_NONE;
            end
            if (pause_sent) begin
                sent_count++;
                sent_cyc = cyc;
            end
        end
    end

    // FIFO-side frame source with up to two pause_req pulses at chosen byte positions
    task automatic send_frame(input int len, input logic [7:0] seed, input logic user,
                              input int req_at, input logic [15:0] req_q,
                              input int req_at2, input logic [15:0] req_q2,
                              output int first_acc);
        beat_t b;
        logic  acc;
        int    waited;
        first_acc = -1;
        for (int i = 0; i < len; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(int'(seed) + i);
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = user;
            b.data = s_if.tdata;
            b.last = s_if.tlast;
            b.user = user;
            b.sent = 1'b0;
            fifo_q.push_back(b);
            if (i == req_at) begin
                pause_req = 1'b1; pause_quanta = req_q;
                model_pending = 1'b1; model_quanta = req_q;
            end
            if (i == req_at2) begin
                pause_req = 1'b1; pause_quanta = req_q2;
                model_pending = 1'b1; model_quanta = req_q2;
            end
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 1000) begin
                @(negedge tx_clk);
                acc = s_if.tready;
                if (acc && i == 0) first_acc = cyc;
                @(posedge tx_clk);
                #1;
                pause_req = 1'b0;
                waited++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: byte %0d not accepted, required accept within 1000 cycles", i);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic pulse_req(input logic [15:0] q);
        pause_req     = 1'b1;
        pause_quanta  = q;
        model_pending = 1'b1;
        model_quanta  = q;
        @(posedge tx_clk);
        #1;
        pause_req = 1'b0;
    endtask

    task automatic wait_sent(input int target, input int budget);
        int n;
        n = 0;
        while (sent_count < target && n < budget) begin
            @(posedge tx_clk);
            #1;
            n++;
        end
        checks++;
        if (sent_count < target) begin
            failures++;
            $display("FAIL wait_sent: pause_sent count %0d, required %0d", sent_count, target);
        end
    endtask

    task automatic wait_pause_idx(input int idx);
        int n;
        n = 0;
        while (!(cur_src == SRC_PAUSE && pause_idx >= idx) && n < 500) begin
            @(posedge tx_clk);
            #1;
            n++;
        end
        checks++;
        if (!(cur_src == SRC_PAUSE && pause_idx >= idx)) begin
            failures++;
            $display("FAIL wait_pause_idx: reached %0d, required %0d", pause_idx, idx);
        end
    endtask

    typedef struct {
        logic       v;  logic [7:0] d;  logic l;  logic u;  logic r;
        logic       ev; logic [7:0] ed; logic el; logic eu; logic er;
    } vec_t;

    vec_t vecs[6];

    initial begin : global_timeout
        #600000;
        $display("FAIL global_timeout: bench did not finish, required finish before 600000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int s0;
        int fa;
        int fa2;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1,  1'b1, 8'h3C, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0,  1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1,  1'b1, 8'h77, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1,  1'b0, 8'h11, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

        tx_rst       = 1'b1;
        pause_req    = 1'b0;
        pause_quanta = '0;
        src_mac      = SRC_MAC;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tlast   = 1'b0;
        s_if.tuser   = 1'b0;

        // Reset state and forwarding while held in reset
        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        chk("rst_busy", 64'(pause_busy), 64'(0));
        chk("rst_sent", 64'(pause_sent), 64'(0));
        s_if.tvalid = 1'b1;
        ready_val   = 1'b0;
        #1;
        chk("rst_fwd", 64'({m_if.tvalid, s_if.tready}), 64'({1'b1, 1'b0}));
        ready_val = 1'b1;
        #1;
        chk("rst_ready", 64'(s_if.tready), 64'(1));
        s_if.tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;

        // Forward-path vector table in IDLE
        for (int i = 0; i < 6; i++) begin
            beat_t b;
            s_if.tvalid = vecs[i].v;
            s_if.tdata  = vecs[i].d;
            s_if.tlast  = vecs[i].l;
            s_if.tuser  = vecs[i].u;
            ready_val   = vecs[i].r;
            if (vecs[i].v && vecs[i].r) begin
                b = {vecs[i].d, vecs[i].l, vecs[i].u, 1'b0};
                fifo_q.push_back(b);
            end
            @(negedge tx_clk);
            chk("vec_fwd",
                64'({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, s_if.tready, pause_busy}),
                64'({vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eu, vecs[i].er, 1'b0}));
            @(posedge tx_clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        ready_val   = 1'b1;
        @(posedge tx_clk);
        #1;

        // Two back-to-back 64-byte frames with no added cycles
        pass_window = 1'b1;
        c0 = cyc;
        send_frame(64, 8'h00, 1'b0, -1, 16'h0, -1, 16'h0, fa);
        send_frame(64, 8'h40, 1'b1, -1, 16'h0, -1, 16'h0, fa);
        chk("pass_cycles", 64'(cyc - c0), 64'(128));
        pass_window = 1'b0;
        chk("pass_busy", 64'(busy_seen), 64'(0));

        // PAUSE from IDLE: pending at N+1, byte 0 at N+2, pause_sent at N+61
        repeat (2) @(posedge tx_clk);
        #1;
        s0 = sent_count;
        c0 = cyc;
        pause_req     = 1'b1;
        pause_quanta  = 16'h1234;
        model_pending = 1'b1;
        model_quanta  = 16'h1234;
        @(negedge tx_clk);
        chk("req_busy_n", 64'(pause_busy), 64'(0));
        @(posedge tx_clk);
        #1;
        pause_req = 1'b0;
        @(negedge tx_clk);
        chk("req_busy_n1", 64'({pause_busy, m_if.tvalid}), 64'({1'b1, 1'b0}));
        @(negedge tx_clk);
        chk("byte0_n2", 64'({m_if.tvalid, m_if.tdata, cyc == c0 + 2}), 64'({1'b1, 8'h01, 1'b1}));
        wait_sent(s0 + 1, 200);
        chk("sent_cycle", 64'(sent_cyc), 64'(c0 + 61));
        @(negedge tx_clk);
        chk("idle_busy_after", 64'(pause_busy), 64'(0));

        // Request at byte 20 of a 100-byte frame; frame 2 waits for the PAUSE frame
        @(posedge tx_clk);
        #1;
        s0 = sent_count;
        send_frame(100, 8'h10, 1'b0, 20, 16'hABCD, -1, 16'h0, fa);
        send_frame(20, 8'h80, 1'b1, -1, 16'h0, -1, 16'h0, fa2);
        chk("mid_sent", 64'(sent_count), 64'(s0 + 1));
        chk("frame2_held", 64'(fa2 > sent_cyc), 64'(1));

        // Random backpressure during PAUSE
        s0 = sent_count;
        rand_mode = 1'b1;
        pulse_req(16'h5A5A);
        wait_sent(s0 + 1, 1000);
        rand_mode = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        chk("bp_one_frame", 64'(sent_count), 64'(s0 + 1));

        // Second request at byte 30 of a PAUSE frame
        s0 = sent_count;
        pulse_req(16'h1111);
        wait_pause_idx(30);
        pulse_req(16'hFFFF);
        wait_sent(s0 + 2, 300);
        repeat (3) @(posedge tx_clk);
        #1;
        chk("two_frames", 64'(sent_count), 64'(s0 + 2));
        chk("two_busy", 64'(pause_busy), 64'(0));

        // Two requests inside one FIFO frame: last quanta wins, single PAUSE frame
        s0 = sent_count;
        send_frame(30, 8'hC0, 1'b0, 5, 16'h0102, 8, 16'h0304, fa);
        wait_sent(s0 + 1, 200);
        repeat (80) @(posedge tx_clk);
        #1;
        chk("b2b_single", 64'(sent_count), 64'(s0 + 1));

        // Reset at byte 10 of a PAUSE frame
        s0 = sent_count;
        pulse_req(16'h7777);
        wait_pause_idx(10);
        tx_rst        = 1'b1;
        cur_src       = SRC_NONE;
        exp_q.delete();
        model_pending = 1'b0;
        s_if.tvalid   = 1'b1;
        s_if.tlast    = 1'b1;
        @(negedge tx_clk);
        chk("rstmid_state", 64'({pause_busy, pause_sent, m_if.tvalid, s_if.tready}),
            64'({1'b0, 1'b0, 1'b1, 1'b1}));
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        repeat (70) @(posedge tx_clk);
        #1;
        chk("rstmid_no_sent", 64'({sent_count == s0, pause_busy, m_if.tvalid}), 64'({1'b1, 1'b0, 1'b0}));
        send_frame(16, 8'h33, 1'b1, -1, 16'h0, -1, 16'h0, fa);

        repeat (5) @(posedge tx_clk);
        #1;
        chk("fifo_q_drained", 64'(fifo_q.size()), 64'(0));
        chk("pause_q_drained", 64'(exp_q.size()), 64'(0));
        chk("total_sent", 64'(sent_count), 64'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
